// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the I/D cache memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side signals of the arbiter, bundled for port connection.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W
);
  // Handshake: a cache holds X_read/X_write (with addr/wdata) until it sees the
  // one-cycle X_ready pulse; the arbiter holds mem_read/mem_write constant until
  // the cycle mem_ready is high, which completes the transfer.
  logic          i_read;
  logic          i_write;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_wdata;
  logic [DW-1:0] i_rdata;
  logic          i_ready;

  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ready;

  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  modport slave (
    input  i_read, i_write, i_addr, i_wdata,
    input  d_read, d_write, d_addr, d_wdata,
    input  mem_rdata, mem_ready,
    output i_rdata, i_ready, d_rdata, d_ready,
    output mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output i_read, i_write, i_addr, i_wdata,
    output d_read, d_write, d_addr, d_wdata,
    output mem_rdata, mem_ready,
    input  i_rdata, i_ready, d_rdata, d_ready,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin pick: on a tie the requester that did not own the last
// transfer wins.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic   req_i_i,
  input  logic   req_d_i,
  input  owner_e last_owner_i,
  output logic   grant_valid_o,
  output owner_e grant_owner_o
);

  always_comb begin
    grant_valid_o = req_i_i | req_d_i;
    grant_owner_o = OWN_I;
    if (req_d_i && (!req_i_i || (last_owner_i == OWN_I))) begin
      grant_owner_o = OWN_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one line-wide memory port between the I-cache and D-cache; one
// transfer in flight, all outputs registered.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic          clk,
  input  logic          proc_reset,
  mem_arbiter_if.slave  bus,
  output state_e        state_o
);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  owner_e              last_owner_q, last_owner_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                i_ready_q, i_ready_d;
  logic                d_ready_q, d_ready_d;

  logic   grant_valid;
  owner_e grant_owner;

  rr_arb2 u_rr_arb2 (
    .req_i_i       (bus.i_read | bus.i_write),
    .req_d_i       (bus.d_read | bus.d_write),
    .last_owner_i  (last_owner_q),
    .grant_valid_o (grant_valid),
    .grant_owner_o (grant_owner)
  );

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_valid) state_d = BUSY;
      BUSY:    if (bus.mem_ready) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_ready_d    = 1'b0;
    d_ready_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          owner_d = grant_owner;
          // Write takes priority if a cache raises both strobes.
          if (grant_owner == OWN_I) begin
            mem_write_d = bus.i_write;
            mem_read_d  = bus.i_read & ~bus.i_write;
            mem_addr_d  = bus.i_addr;
            mem_wdata_d = bus.i_wdata;
          end else begin
            mem_write_d = bus.d_write;
            mem_read_d  = bus.d_read & ~bus.d_write;
            mem_addr_d  = bus.d_addr;
            mem_wdata_d = bus.d_wdata;
          end
        end
      end
      BUSY: begin
        if (bus.mem_ready) begin
          mem_read_d   = 1'b0;
          mem_write_d  = 1'b0;
          last_owner_d = owner_q;
          if (owner_q == OWN_I) begin
            i_ready_d = 1'b1;
            if (mem_read_q) i_rdata_d = bus.mem_rdata;
          end else begin
            d_ready_d = 1'b1;
            if (mem_read_q) d_rdata_d = bus.mem_rdata;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      owner_q      <= OWN_I;
      last_owner_q <= OWN_I;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_ready_q    <= 1'b0;
      d_ready_q    <= 1'b0;
    end else begin
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      i_ready_q    <= i_ready_d;
      d_ready_q    <= d_ready_d;
    end
  end

  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.i_ready   = i_ready_q;
  assign bus.d_ready   = d_ready_q;
  assign state_o       = state_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares one slow block memory between the instruction cache and the data cache. Each cache keeps its existing 128-bit line-refill/write-back port; the arbiter grants one at a time, forwards the granted request to the single memory port, and returns data and a one-cycle ready to the owner. It sits between the I/D caches and off-chip memory, replacing the separate memI/memD ports at chip level.

## Interface

- ADDR_W, 28, line address width (byte address bits 31:4)
- DATA_W, 128, line width in bits
- clk  in  1  single clock, all state on rising edge
- proc_reset  in  1  asynchronous, active-high reset
- i_read, i_write  in  1 each  I-cache request strobes, held until i_ready
- i_addr  in  ADDR_W  I-cache line address
- i_wdata  in  DATA_W  I-cache write line
- i_rdata  out  DATA_W  read line returned to I-cache
- i_ready  out  1  one-cycle completion pulse to I-cache
- d_read, d_write, d_addr, d_wdata, d_rdata, d_ready: same as i_* for D-cache
- mem_read, mem_write  out  1 each  memory request strobes
- mem_addr  out  ADDR_W  memory line address
- mem_wdata  out  DATA_W  memory write line
- mem_rdata  in  DATA_W  memory read line, valid with mem_ready
- mem_ready  in  1  memory completion, may arrive any cycle after request

## Operation

- States: IDLE, BUSY, RESP.
- IDLE: requester X is "requesting" if X_read|X_write. None -> stay IDLE. One -> grant it. Both -> grant the requester not granted last (last_owner register, reset value I, so D wins the first tie).
- Grant (IDLE->BUSY): register owner, addr, wdata; mem_write <= X_write; mem_read <= X_read & ~X_write (write wins if both asserted).
- BUSY: memory outputs held constant; requester inputs ignored (changes or drop of request do not abort). On mem_ready: capture mem_rdata into owner's rdata register (reads only; writes leave it), clear mem_read/mem_write, go RESP, update last_owner.
- RESP: owner's X_ready = 1 for exactly this cycle; other requester's ready stays 0; mem_ready ignored; next state IDLE unconditionally.
- IDLE arbitrates on the request values present after the owner has seen ready, so a cache's follow-on request (write-back then refill) is a fresh request and competes normally.
- X_rdata holds its last value until overwritten by that requester's next read completion.
- mem_ready in IDLE or RESP is ignored.

## Timing

- Reset (async, immediate): state IDLE, last_owner I, mem_read/mem_write/i_ready/d_ready 0, mem_addr/mem_wdata/i_rdata/d_rdata 0.
- Request asserted in cycle t with arbiter IDLE -> mem_read/write visible in t+1.
- mem_ready high in cycle m (arbiter BUSY) -> X_ready and X_rdata valid in m+1; memory strobes low in m+1.
- Earliest next grant: IDLE in m+2, memory strobes in m+3. Minimum arbitration overhead 3 cycles beyond memory latency.
- No combinational path from any input to any output; all outputs registered.
- Reset asserted in BUSY: transaction abandoned, outputs zero same cycle; any later mem_ready ignored until a new grant.
- Starvation bound: with both requesting continuously, grants alternate I/D strictly.

## Structure

- Package mem_arb_pkg: state enum (IDLE, BUSY, RESP), owner enum (OWN_I, OWN_D), ADDR_W/DATA_W defaults.
- Sub-module rr_arb2: combinational two-requester round-robin pick (req_i, req_d, last_owner -> grant_valid, grant_owner); FSM and datapath registers stay in mem_arbiter.

## Test plan

- Reset: hold proc_reset 3 cycles mid-BUSY -> all outputs 0 immediately, state IDLE; release, no spurious strobes.
- Single I read addr 0x0000123, memory ready after 5 cycles with 0xA5..A5 -> mem_read high t+1 to m, i_ready one cycle at m+1, i_rdata = 0xA5..A5, d_ready stays 0.
- Simultaneous I read and D write after reset -> D granted first (mem_write, d_addr/d_wdata forwarded), then I; continuous dual requests -> grants alternate D,I,D,I.
- D write-back then refill (d_write drops, d_read rises on ready cycle) with I requesting -> I granted between them per round-robin.
- Requester drops i_read during BUSY -> memory transaction completes, i_ready still pulses once; mem_ready pulses in IDLE/RESP produce no ready.
- Both i_read and i_write high -> mem_write=1, mem_read=0; i_rdata unchanged after completion.
